// File: rtl/stream_packer_pkg.sv
// rtl/stream_packer_pkg.sv - shared state type and geometry helpers for the stream packer
package stream_packer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Number of input words per output beat.
   function automatic int sp_ratio(input int data_w, input int in_w);
      return data_w / in_w;
   endfunction

   // fill must be able to count 0..R inclusive.
   function automatic int sp_fill_width(input int ratio);
      return $clog2(ratio) + 1;
   endfunction

endpackage

// File: rtl/stream_packer_if.sv
// rtl/stream_packer_if.sv - narrow-in / wide-out handshake bundle of the stream packer
interface stream_packer_if #(
   parameter int C_DATA_WIDTH = 64,
   parameter int C_IN_WIDTH   = 16
);
   import stream_packer_pkg::*;

   localparam int R  = sp_ratio(C_DATA_WIDTH, C_IN_WIDTH);
   localparam int FW = sp_fill_width(R);

   logic                    in_valid;
   logic                    in_ready;
   logic [C_IN_WIDTH-1:0]   in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [C_DATA_WIDTH-1:0] out_data;
   logic [R-1:0]            out_keep;
   logic                    out_last;
   logic [FW-1:0]           fill;

   modport master (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last, fill
   );

   modport slave (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last, fill
   );

endinterface

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs C_IN_WIDTH words into C_DATA_WIDTH beats ahead of a FIFO write port
module stream_packer
   import stream_packer_pkg::*;
#(
   parameter int C_DATA_WIDTH = 64,
   parameter int C_IN_WIDTH   = 16
) (
   input  logic            clk,
   input  logic            resetn,
   stream_packer_if.master bus
);

   localparam int R  = sp_ratio(C_DATA_WIDTH, C_IN_WIDTH);
   localparam int FW = sp_fill_width(R);
   localparam int LW = (R > 1) ? $clog2(R) : 1;

   generate
      if ((C_DATA_WIDTH % C_IN_WIDTH) != 0 || R < 2) begin : g_bad_ratio
         $error("stream_packer: C_DATA_WIDTH/C_IN_WIDTH must be an integer >= 2");
      end
   endgenerate

   state_t                  state_q, state_n;
   logic [FW-1:0]           fill_q, fill_n;
   logic [C_DATA_WIDTH-1:0] data_q, data_n;
   logic [R-1:0]            keep_q, keep_n;
   logic                    last_q, last_n;
   logic                    run_q;
   logic                    in_fire;
   logic                    out_fire;
   logic [LW-1:0]           lane;

   // run_q keeps the input closed for the cycle in which reset is released.
   assign bus.in_ready = run_q && ((state_q == FILL) || bus.out_ready);
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign out_fire     = (state_q == HOLD) && bus.out_ready;
   assign lane         = fill_q[LW-1:0];

   always_comb begin
      state_n = state_q;
      fill_n  = fill_q;
      data_n  = data_q;
      keep_n  = keep_q;
      last_n  = last_q;
      case (state_q)
         FILL: begin
            if (in_fire) begin
               for (int i = 0; i < R; i++) begin
                  if (lane == LW'(i)) begin
                     data_n[i*C_IN_WIDTH +: C_IN_WIDTH] = bus.in_data;
                     keep_n[i]                          = 1'b1;
                  end
               end
               fill_n = fill_q + FW'(1);
               last_n = bus.in_last;
               if (bus.in_last || (fill_q == FW'(R - 1)))
                  state_n = HOLD;
            end
         end
         HOLD: begin
            if (out_fire) begin
               state_n = FILL;
               fill_n  = '0;
               data_n  = '0;
               keep_n  = '0;
               last_n  = 1'b0;
               // Word arriving alongside the drain opens the next beat: no bubble.
               if (in_fire) begin
                  data_n[C_IN_WIDTH-1:0] = bus.in_data;
                  keep_n[0]              = 1'b1;
                  fill_n                 = FW'(1);
                  last_n                 = bus.in_last;
                  if (bus.in_last)
                     state_n = HOLD;
               end
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FILL;
         fill_q  <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         fill_q  <= fill_n;
         data_q  <= data_n;
         keep_q  <= keep_n;
         last_q  <= last_n;
         run_q   <= 1'b1;
      end
   end

   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = data_q;
   assign bus.out_keep  = keep_q;
   assign bus.out_last  = last_q;
   assign bus.fill      = fill_q;

endmodule
